// File: rtl/iobus_timer_intc.sv
// Memory-mapped down-counter timer with prescaler and a level interrupt (PEND & IE).
// Read data is combinational from the address. There is no backpressure: every write is accepted in one cycle.
module iobus_timer_intc #(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0300
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   output logic        INTR
);

   logic        r_en;
   logic        r_ar;
   logic        r_ie;
   logic [31:0] r_reload;
   logic [31:0] r_count;
   logic        r_pend;
   logic [7:0]  r_prescale;
   logic [7:0]  r_ps;

   logic w_sel_ctrl, w_sel_reload, w_sel_count, w_sel_status, w_sel_prescale;
   logic w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_status, w_wr_prescale;
   logic w_tick;
   logic w_expire;

   assign w_sel_ctrl     = (IOBUS_ADDR == BASE_ADDR);
   assign w_sel_reload   = (IOBUS_ADDR == BASE_ADDR + 32'h4);
   assign w_sel_count    = (IOBUS_ADDR == BASE_ADDR + 32'h8);
   assign w_sel_status   = (IOBUS_ADDR == BASE_ADDR + 32'hC);
   assign w_sel_prescale = (IOBUS_ADDR == BASE_ADDR + 32'h10);

   assign w_wr_ctrl     = IOBUS_WR & w_sel_ctrl;
   assign w_wr_reload   = IOBUS_WR & w_sel_reload;
   assign w_wr_count    = IOBUS_WR & w_sel_count;
   assign w_wr_status   = IOBUS_WR & w_sel_status;
   assign w_wr_prescale = IOBUS_WR & w_sel_prescale;

   assign w_tick   = r_en & (r_ps == r_prescale);
   // A COUNT write in the same cycle suppresses the expiry as well as the decrement.
   assign w_expire = w_tick & (r_count == 32'h0) & ~w_wr_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_en <= 1'b0;
         r_ar <= 1'b0;
         r_ie <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en <= IOBUS_OUT[0];
         r_ar <= IOBUS_OUT[1];
         r_ie <= IOBUS_OUT[2];
      end else if (w_expire && !r_ar) begin
         r_en <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_reload   <= 32'h0;
         r_prescale <= 8'h0;
      end else begin
         if (w_wr_reload)   r_reload   <= IOBUS_OUT;
         if (w_wr_prescale) r_prescale <= IOBUS_OUT[7:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ps <= 8'h0;
      end else if (w_wr_ctrl || !r_en || w_tick) begin
         r_ps <= 8'h0;
      end else begin
         r_ps <= r_ps + 8'h1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= 32'h0;
      end else if (w_wr_count) begin
         r_count <= IOBUS_OUT;
      end else if (w_tick) begin
         if (r_count != 32'h0) begin
            r_count <= r_count - 32'h1;
         end else if (r_ar) begin
            r_count <= r_reload;
         end
      end
   end

   // Expiry beats a coincident software clear so an event is never lost.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pend <= 1'b0;
      end else if (w_expire) begin
         r_pend <= 1'b1;
      end else if (w_wr_status && IOBUS_OUT[0]) begin
         r_pend <= 1'b0;
      end
   end

   always_comb begin
      IOBUS_IN = 32'h0;
      if (w_sel_ctrl)          IOBUS_IN = {29'h0, r_ie, r_ar, r_en};
      else if (w_sel_reload)   IOBUS_IN = r_reload;
      else if (w_sel_count)    IOBUS_IN = r_count;
      else if (w_sel_status)   IOBUS_IN = {31'h0, r_pend};
      else if (w_sel_prescale) IOBUS_IN = {24'h0, r_prescale};
   end

   assign INTR = r_pend & r_ie;

endmodule

// File: tb/tb_iobus_timer_intc.sv
// Directed bench: the driver queues expected read data and INTR per read cycle; a monitor checks on the falling edge.
module tb_iobus_timer_intc;

   localparam logic [31:0] BASE = 32'h1100_0300;
   localparam logic [31:0] O_CTRL = 32'h0, O_RELOAD = 32'h4, O_COUNT = 32'h8;
   localparam logic [31:0] O_STATUS = 32'hC, O_PRESCALE = 32'h10;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] IOBUS_ADDR = 32'h0;
   logic [31:0] IOBUS_OUT = 32'h0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] IOBUS_IN;
   logic        INTR;

   logic chk_vld = 1'b0;
   bit   done = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   typedef struct {
      logic [31:0] dat;
      logic        intr;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   iobus_timer_intc #(.BASE_ADDR(BASE)) dut (
      .CLK(CLK),
      .RST(RST),
      .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT(IOBUS_OUT),
      .IOBUS_WR(IOBUS_WR),
      .IOBUS_IN(IOBUS_IN),
      .INTR(INTR)
   );

   always #5 CLK = ~CLK;

   // Monitor: pops one expectation for each flagged read cycle.
   always @(negedge CLK) begin
      if (chk_vld && !done) begin
         if (exp_q.size() == 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL unexpected_read: read flagged with empty queue, required an expectation");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec = n_vec + 2;
            if (IOBUS_IN !== e.dat) begin
               n_bad = n_bad + 1;
               $display("FAIL %s: IOBUS_IN got %h required %h", e.name, IOBUS_IN, e.dat);
            end
            if (INTR !== e.intr) begin
               n_bad = n_bad + 1;
               $display("FAIL %s_intr: INTR got %b required %b", e.name, INTR, e.intr);
            end
         end
      end
   end

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      IOBUS_ADDR = BASE + off;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      chk_vld    = 1'b0;
      @(posedge CLK);
      #1;
      IOBUS_WR   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] d, input logic i, input string nm);
      IOBUS_ADDR = BASE + off;
      IOBUS_WR   = 1'b0;
      exp_q.push_back('{dat: d, intr: i, name: nm});
      chk_vld    = 1'b1;
      @(posedge CLK);
      #1;
      chk_vld    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset state: everything reads zero.
      rd(O_CTRL, 32'h0, 1'b0, "rst_ctrl");
      rd(O_RELOAD, 32'h0, 1'b0, "rst_reload");
      rd(O_COUNT, 32'h0, 1'b0, "rst_count");
      rd(O_STATUS, 32'h0, 1'b0, "rst_status");
      rd(O_PRESCALE, 32'h0, 1'b0, "rst_prescale");

      // Readback and field masking.
      wr(O_RELOAD, 32'hDEAD_BEEF);
      wr(O_PRESCALE, 32'h1FF);
      wr(O_CTRL, 32'hFF);
      rd(O_RELOAD, 32'hDEAD_BEEF, 1'b0, "rb_reload");
      rd(O_PRESCALE, 32'hFF, 1'b0, "rb_prescale");
      rd(O_CTRL, 32'h7, 1'b0, "rb_ctrl");
      rd(32'h14, 32'h0, 1'b0, "rb_unmapped");
      rd(32'h2, 32'h0, 1'b0, "rb_unaligned");
      wr(O_CTRL, 32'h0);
      rd(O_COUNT, 32'h0, 1'b0, "rb_count");

      // One-shot: expiry on the 4th edge after the CTRL write.
      wr(O_PRESCALE, 32'h0);
      wr(O_COUNT, 32'h3);
      wr(O_CTRL, 32'h5);
      rd(O_COUNT, 32'h3, 1'b0, "os_c0");
      rd(O_COUNT, 32'h2, 1'b0, "os_c1");
      rd(O_COUNT, 32'h1, 1'b0, "os_c2");
      rd(O_COUNT, 32'h0, 1'b0, "os_c3");
      rd(O_STATUS, 32'h1, 1'b1, "os_pend");
      rd(O_CTRL, 32'h4, 1'b1, "os_en_clr");
      rd(O_COUNT, 32'h0, 1'b1, "os_hold");
      wr(O_STATUS, 32'h1);
      rd(O_STATUS, 32'h0, 1'b0, "os_clear");

      // CTRL write coincident with expiry keeps the written EN.
      wr(O_CTRL, 32'h5);
      wr(O_CTRL, 32'h5);
      rd(O_CTRL, 32'h5, 1'b1, "cw_ctrl_wins");
      rd(O_CTRL, 32'h4, 1'b1, "cw_oneshot");
      wr(O_STATUS, 32'h1);
      wr(O_CTRL, 32'h0);
      rd(O_STATUS, 32'h0, 1'b0, "cw_clear");

      // Auto-reload with prescale 2: period of 6 cycles.
      wr(O_PRESCALE, 32'h2);
      wr(O_RELOAD, 32'h1);
      wr(O_COUNT, 32'h1);
      wr(O_CTRL, 32'h7);
      rd(O_COUNT, 32'h1, 1'b0, "ar_c0");
      rd(O_COUNT, 32'h1, 1'b0, "ar_c1");
      rd(O_COUNT, 32'h1, 1'b0, "ar_c2");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c3");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c4");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c5");
      rd(O_COUNT, 32'h1, 1'b1, "ar_exp1");
      wr(O_STATUS, 32'h1);
      rd(O_COUNT, 32'h1, 1'b0, "ar_c8");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c9");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c10");
      rd(O_COUNT, 32'h0, 1'b0, "ar_c11");
      rd(O_COUNT, 32'h1, 1'b1, "ar_exp2");

      // Clear coincident with expiry: PEND stays set.
      wr(O_STATUS, 32'h1);
      rd(O_COUNT, 32'h1, 1'b0, "cc_c14");
      rd(O_COUNT, 32'h0, 1'b0, "cc_c15");
      rd(O_COUNT, 32'h0, 1'b0, "cc_c16");
      wr(O_STATUS, 32'h1);
      rd(O_STATUS, 32'h1, 1'b1, "cc_set_wins");
      rd(O_COUNT, 32'h1, 1'b1, "cc_c19");

      // COUNT write on a tick edge wins over the decrement.
      wr(O_COUNT, 32'd10);
      rd(O_COUNT, 32'd10, 1'b1, "col_c21");
      rd(O_COUNT, 32'd10, 1'b1, "col_c22");
      rd(O_COUNT, 32'd10, 1'b1, "col_c23");
      rd(O_COUNT, 32'd9, 1'b1, "col_dec");

      // Reset mid-run, with a coincident COUNT write that must lose.
      IOBUS_ADDR = BASE + O_COUNT;
      IOBUS_OUT  = 32'h55;
      IOBUS_WR   = 1'b1;
      RST        = 1'b1;
      @(posedge CLK);
      #1;
      RST        = 1'b0;
      IOBUS_WR   = 1'b0;
      rd(O_CTRL, 32'h0, 1'b0, "mr_ctrl");
      rd(O_RELOAD, 32'h0, 1'b0, "mr_reload");
      rd(O_COUNT, 32'h0, 1'b0, "mr_count");
      rd(O_STATUS, 32'h0, 1'b0, "mr_status");
      rd(O_PRESCALE, 32'h0, 1'b0, "mr_prescale");
      for (int k = 0; k < 6; k++) begin
         rd(O_STATUS, 32'h0, 1'b0, "mr_no_tick");
      end

      @(negedge CLK);
      done  = 1'b1;
      n_vec = n_vec + 1;
      if (exp_q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/iobus_timer_intc.md
IOBUS_TIMER_INTC -- requirements
Module: iobus_timer_intc

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1100_0300, is the word-aligned base of the 5-register block (offsets 0x00-0x10).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 IOBUS_ADDR  input  32  byte address from the MCU.
REQ-005 IOBUS_OUT  input  32  write data from the MCU.
REQ-006 IOBUS_WR  input  1  write strobe; one write per cycle it is high.
REQ-007 IOBUS_IN  output  32  read data to the MCU.
REQ-008 INTR  output  1  level interrupt request to the MCU.

Function
REQ-009 Register map: offset 0x00 CTRL; 0x04 RELOAD; 0x08 COUNT; 0x0C STATUS; 0x10 PRESCALE.
REQ-010 CTRL bits: [0] EN (count enable), [1] AR (auto-reload), [2] IE (interrupt enable); bits [31:3] read 0 and ignore writes.
REQ-011 RELOAD: 32-bit read/write.
REQ-012 COUNT: 32-bit; a read returns the live counter; a write loads it directly.
REQ-013 STATUS: bit [0] PEND; a read returns {31'b0, PEND}; writing 1 to bit 0 clears PEND; writing 0 has no effect.
REQ-014 PRESCALE: 8-bit read/write in bits [7:0]; bits [31:8] read 0.
REQ-015 Decode is full 32-bit: a register is selected only when IOBUS_ADDR equals BASE_ADDR + offset exactly; bits [1:0] must be 0.
REQ-016 A write takes effect on the CLK edge where IOBUS_WR=1 and the address decodes; writes to any other address are ignored.
REQ-017 IOBUS_IN is combinational from IOBUS_ADDR and current register state, with zero latency and independent of IOBUS_WR.
REQ-018 IOBUS_IN is 32'h0 for any address that does not decode.
REQ-019 Prescaler: internal 8-bit counter PS; while EN=1, PS increments each cycle.
REQ-020 When PS==PRESCALE, PS returns to 0 and a one-cycle tick fires instead of incrementing, so a tick occurs every PRESCALE+1 cycles.
REQ-021 While EN=0, PS holds at 0 and no ticks occur.
REQ-022 Any CTRL write clears PS to 0.
REQ-023 On a tick with COUNT!=0: COUNT decrements by 1.
REQ-024 On a tick with COUNT==0 (expiry): PEND is set to 1.
REQ-025 At expiry with AR=1: COUNT loads RELOAD and EN stays 1.
REQ-026 At expiry with AR=0: COUNT stays 0 and EN clears to 0 (one-shot).
REQ-027 Simultaneous COUNT write and tick: the write wins; no decrement and no expiry that cycle.
REQ-028 Simultaneous CTRL write and expiry: the written CTRL value wins, including EN.
REQ-029 Simultaneous STATUS clear and expiry: the set wins and PEND stays 1.
REQ-030 INTR = PEND & IE, with no extra register stage.
REQ-031 INTR stays high until software clears PEND or clears IE; it must be held so the multicycle FSM cannot miss it.
REQ-032 RELOAD=0 with AR=1: expiry occurs on every tick.
REQ-033 Counter arithmetic is unsigned 32-bit; no decrement below 0 and no wrap.

Reset
REQ-034 While RST=1 at a CLK edge: CTRL=0, RELOAD=0, COUNT=0, PRESCALE=0, PS=0, PEND=0.
REQ-035 Reset has priority over every write and tick in the same cycle.
REQ-036 Reset mid-count aborts the count; INTR is 0 in the cycle after the reset edge.
REQ-037 With all registers at reset value, IOBUS_IN=0 for every address.

Verification
REQ-038 Readback: write RELOAD=32'hDEAD_BEEF, PRESCALE=32'h1FF, CTRL=32'hFF -> reads return 32'hDEAD_BEEF, 32'hFF and 32'h7; address BASE+0x14 reads 0.
REQ-039 One-shot: PRESCALE=0, COUNT=3, CTRL=5 -> PEND and INTR rise on the 4th cycle after the CTRL write; EN then reads 0; COUNT stays 0.
REQ-040 Auto-reload with prescale: PRESCALE=2, RELOAD=1, COUNT=1, CTRL=7 -> INTR first rises 6 cycles after the CTRL write; COUNT reads 1 right after expiry; the period is 6 cycles.
REQ-041 Clear handshake: with INTR=1, write STATUS=1 -> INTR=0 next cycle. Also, a STATUS clear coincident with an expiry -> INTR stays 1.
REQ-042 Write collision: a COUNT=10 write on a tick cycle -> COUNT reads 10 the next cycle, not 9.
REQ-043 Reset mid-operation: assert RST for one cycle while running with INTR=1 -> all registers read 0, INTR=0, and no ticks occur afterwards.
